// File: rtl/mux_rr_sched.sv
// mux_rr_sched: buffers one word per channel and feeds a 4:1 mux with round-robin selects.
// Define MUX_RR_B2B_EN for back-to-back presentation without an IDLE bubble.
module mux_rr_sched #(
  parameter int DW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
  output logic [DW-1:0]   a,
  output logic [DW-1:0]   b,
  output logic [DW-1:0]   c,
  output logic [DW-1:0]   d,
  output logic [1:0]      sel,
  output logic            out_valid,
  input  logic            out_ready
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t        state_q;
  logic [DW-1:0] data_q [4];
  logic [3:0]    full_q, full_d, load, clr;
  logic [1:0]    last_q, sel_q, idle_idx;
  logic          out_valid_q, fire, idle_hit;
  // First set bit of m searching base+1, base+2, base+3, base; returns {hit, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] m, input logic [1:0] base);
    logic [2:0] r;
    logic [1:0] ch;
    r = '0;
    for (int k = 4; k >= 1; k--) begin
      ch = base + 2'(k);
      if (m[ch]) r = {1'b1, ch};
    end
    return r;
  endfunction
  assign fire = out_valid_q & out_ready;
  assign load = in_valid & ~full_q;
  assign clr = fire ? (4'b1 << sel_q) : 4'b0;
  assign full_d = (full_q | load) & ~clr;
  assign {idle_hit, idle_idx} = rr_pick(full_q, last_q);
`ifdef MUX_RR_B2B_EN
  logic       b2b_hit;
  logic [1:0] b2b_idx;
  assign {b2b_hit, b2b_idx} = rr_pick(full_q & ~(4'b1 << sel_q), sel_q);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      full_q <= '0;
      last_q <= 2'd3;
      sel_q <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      full_q <= full_d;
      for (int i = 0; i < 4; i++) if (load[i]) data_q[i] <= in_data[i*DW +: DW];
      if (state_q == IDLE) begin
        if (idle_hit) begin
          sel_q <= idle_idx;
          out_valid_q <= 1'b1;
          state_q <= PRESENT;
        end
      end else if (out_ready) begin
        last_q <= sel_q;
`ifdef MUX_RR_B2B_EN
        if (b2b_hit) sel_q <= b2b_idx;
        else begin
          out_valid_q <= 1'b0;
          state_q <= IDLE;
        end
`else
        out_valid_q <= 1'b0;
        state_q <= IDLE;
`endif
      end
    end
  end
  assign in_ready = ~full_q;
  assign {a, b, c, d} = {data_q[0], data_q[1], data_q[2], data_q[3]};
  assign sel = sel_q;
  assign out_valid = out_valid_q;
endmodule
